// File: rtl/mu_writeback_ctrl.sv
// rtl/mu_writeback_ctrl.sv - packs MAC result vectors and writes them to the result SRAM
// Optional: define MU_WB_SATURATE_EN to clamp channels instead of truncating them.
module mu_writeback_ctrl #(
    parameter int N_CH      = 4,
    parameter int W_MU      = 17,
    parameter int W_PACK    = 16,
    parameter int RAM_W     = 32,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256,
    parameter int NUM_VEC   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_CH*W_MU-1:0]   mu_in,
    input  logic                   ram_ry,
    output logic                   ram_cs_n,
    output logic                   ram_we_n,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [RAM_W-1:0]       ram_wdata,
    output logic                   row_done,
    output logic                   ram_done,
    output logic                   busy,
    output logic                   overflow
);

    localparam int WPV   = N_CH * W_PACK / RAM_W;
    localparam int IDX_W = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int CNT_W = $clog2(NUM_VEC + 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state, state_nx;
    logic [ADDR_W-1:0]       addr;
    logic [IDX_W-1:0]        word_idx;
    logic [CNT_W-1:0]        vec_cnt;
    logic [N_CH*W_PACK-1:0]  packed_q;
    logic [N_CH*W_PACK-1:0]  packed_in;
    logic                    last_word;
    logic                    last_vec;

    function automatic logic [W_PACK-1:0] reduce_ch(input logic [W_MU-1:0] v);
`ifdef MU_WB_SATURATE_EN
        if ((v >> W_PACK) != '0)
            return '1;
        else
            return W_PACK'(v);
`else
        return W_PACK'(v);
`endif
    endfunction

    // Channel 0 lands in the LSBs, so word k is simply slice k of the packed vector.
    always_comb begin
        packed_in = '0;
        for (int k = 0; k < N_CH; k++)
            packed_in[k*W_PACK +: W_PACK] = reduce_ch(mu_in[k*W_MU +: W_MU]);
    end

    assign last_word = (word_idx == IDX_W'(WPV - 1));
    assign last_vec  = (vec_cnt == CNT_W'(NUM_VEC - 1));

    // Address and data come straight from registers, so they hold through WAIT.
    assign ram_addr  = addr;
    assign ram_wdata = packed_q[word_idx*RAM_W +: RAM_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        ram_cs_n = 1'b1;
        ram_we_n = 1'b1;
        row_done = 1'b0;
        ram_done = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_ACCEPT;
            end
            S_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = S_WRITE;
            end
            S_WRITE: begin
                ram_cs_n = 1'b0;
                ram_we_n = 1'b0;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (ram_ry) begin
                    if (!last_word) begin
                        state_nx = S_WRITE;
                    end else begin
                        row_done = 1'b1;
                        state_nx = last_vec ? S_DONE : S_ACCEPT;
                    end
                end
            end
            S_DONE: begin
                ram_done = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= FIRST_ADDR;
            word_idx <= '0;
            vec_cnt  <= '0;
            packed_q <= '0;
            overflow <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                addr     <= FIRST_ADDR;
                vec_cnt  <= '0;
                overflow <= 1'b0;
            end
            if (state == S_ACCEPT && in_valid) begin
                packed_q <= packed_in;
                word_idx <= '0;
            end
            if (state == S_WAIT && ram_ry) begin
                if (addr == LAST_ADDR) begin
                    addr     <= FIRST_ADDR;
                    overflow <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
                if (last_word)
                    vec_cnt <= vec_cnt + 1'b1;
                else
                    word_idx <= word_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mu_writeback_ctrl.sv
// tb/tb_mu_writeback_ctrl.sv - directed bench for mu_writeback_ctrl (default and small-wrap instances)
module tb_mu_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        in_valid = 1'b0;
    logic [67:0] mu_in = '0;
    logic        ram_ry = 1'b1;

    logic        in_ready, ram_cs_n, ram_we_n, row_done, ram_done, busy, overflow;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        in_ready2, ram_cs_n2, ram_we_n2, row_done2, ram_done2, busy2, overflow2;
    logic [7:0]  ram_addr2;
    logic [31:0] ram_wdata2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int row_cnt = 0, done_cnt = 0, last_row_cyc = 0, done_cyc = 0, ready_viol = 0;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  wr_addr2[$];
    logic        wr_ovf2[$];

    mu_writeback_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .mu_in(mu_in), .ram_ry(ram_ry), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .row_done(row_done),
        .ram_done(ram_done), .busy(busy), .overflow(overflow)
    );

    mu_writeback_ctrl #(.DEPTH(4), .NUM_VEC(3)) u_wrap (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .mu_in(mu_in), .ram_ry(ram_ry), .ram_cs_n(ram_cs_n2), .ram_we_n(ram_we_n2),
        .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .row_done(row_done2),
        .ram_done(ram_done2), .busy(busy2), .overflow(overflow2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (!ram_cs_n && !ram_we_n) begin
                wr_addr.push_back(ram_addr);
                wr_data.push_back(ram_wdata);
                if (in_ready) ready_viol++;
            end
            if (!busy && in_ready) ready_viol++;
            if (row_done) begin
                row_cnt++;
                last_row_cyc = cyc;
            end
            if (ram_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!ram_cs_n2 && !ram_we_n2) begin
                wr_addr2.push_back(ram_addr2);
                wr_ovf2.push_back(overflow2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] pat_ch(input int v, input int k);
        return 17'(v * 16 + k + 1);
    endfunction

    function automatic logic [67:0] pat_vec(input int v);
        logic [67:0] r;
        for (int k = 0; k < 4; k++) r[k*17 +: 17] = pat_ch(v, k);
        return r;
    endfunction

    task automatic send_vec(input logic sel, input logic [67:0] vec);
        logic rdy;
        mu_in = vec;
        in_valid = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rdy = sel ? in_ready2 : in_ready;
            if (rdy === 1'b1) break;
            tick;
        end
        check("handshake_ready", 64'(rdy), 64'd1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input logic sel);
        logic d;
        d = 1'b0;
        for (int i = 0; i < 60; i++) begin
            d = sel ? ram_done2 : ram_done;
            if (d === 1'b1) break;
            tick;
        end
        check("ram_done_seen", 64'(d), 64'd1);
        tick;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_cs_n"}, 64'(ram_cs_n), 64'd1);
        check({tag, "_we_n"}, 64'(ram_we_n), 64'd1);
        check({tag, "_addr"}, 64'(ram_addr), 64'd0);
        check({tag, "_wdata"}, 64'(ram_wdata), 64'd0);
        check({tag, "_row_done"}, 64'(row_done), 64'd0);
        check({tag, "_ram_done"}, 64'(ram_done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        logic [31:0] exp_w0, exp_w1, exp_d;
        int n0;

`ifdef MU_WB_SATURATE_EN
        exp_w0 = 32'h1234FFFF;
        exp_w1 = 32'hFFFFFFFF;
`else
        exp_w0 = 32'h1234ABCD;
        exp_w1 = 32'h0000FFFF;
`endif

        // Reset state
        tick;
        tick;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick;

        // Single vector, first of a full job
        start = 1'b1;
        tick;
        start = 1'b0;
        check("accept_in_ready", 64'(in_ready), 64'd1);
        check("accept_busy", 64'(busy), 64'd1);
        mu_in = pat_vec(0);
        in_valid = 1'b1;
        ram_ry = 1'b1;
        tick;
        in_valid = 1'b0;
        check("w0_cs_n", 64'(ram_cs_n), 64'd0);
        check("w0_we_n", 64'(ram_we_n), 64'd0);
        check("w0_addr", 64'(ram_addr), 64'd0);
        check("w0_wdata", 64'(ram_wdata), 64'h00020001);
        check("w0_in_ready", 64'(in_ready), 64'd0);
        tick;
        check("wait0_cs_n", 64'(ram_cs_n), 64'd1);
        check("wait0_addr", 64'(ram_addr), 64'd0);
        check("wait0_wdata", 64'(ram_wdata), 64'h00020001);
        check("wait0_row_done", 64'(row_done), 64'd0);
        check("wait0_in_ready", 64'(in_ready), 64'd0);
        tick;
        check("w1_cs_n", 64'(ram_cs_n), 64'd0);
        check("w1_addr", 64'(ram_addr), 64'd1);
        check("w1_wdata", 64'(ram_wdata), 64'h00040003);
        tick;
        check("wait1_row_done", 64'(row_done), 64'd1);
        tick;
        check("accept1_in_ready", 64'(in_ready), 64'd1);
        check("accept1_row_done", 64'(row_done), 64'd0);

        // Remainder of the full job
        for (int v = 1; v < 8; v++) send_vec(1'b0, pat_vec(v));
        wait_done(1'b0);
        check("job_write_count", 64'(wr_addr.size()), 64'd16);
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            exp_d = {15'd0, pat_ch(i / 2, 2 * (i % 2) + 1)} << 16 | {15'd0, pat_ch(i / 2, 2 * (i % 2))};
            check($sformatf("job_addr_%0d", i), 64'(wr_addr[i]), 64'(i));
            check($sformatf("job_data_%0d", i), 64'(wr_data[i]), 64'(exp_d));
        end
        check("job_row_done_count", 64'(row_cnt), 64'd8);
        check("job_ram_done_count", 64'(done_cnt), 64'd1);
        check("job_done_after_row", 64'(done_cyc - last_row_cyc), 64'd1);
        check("job_in_ready_outside_accept", 64'(ready_viol), 64'd0);
        check("job_idle_busy", 64'(busy), 64'd0);

        // SRAM stall plus reduction boundaries
        start = 1'b1;
        tick;
        start = 1'b0;
        ram_ry = 1'b0;
        send_vec(1'b0, {17'h10000, 17'h0FFFF, 17'h01234, 17'h1ABCD});
        n0 = wr_addr.size();
        check("stall_w0_cs_n", 64'(ram_cs_n), 64'd0);
        check("stall_w0_addr", 64'(ram_addr), 64'd0);
        check("reduce_word0", 64'(ram_wdata), 64'(exp_w0));
        for (int i = 0; i < 5; i++) begin
            tick;
            check($sformatf("stall_cs_n_%0d", i), 64'(ram_cs_n), 64'd1);
            check($sformatf("stall_we_n_%0d", i), 64'(ram_we_n), 64'd1);
            check($sformatf("stall_addr_%0d", i), 64'(ram_addr), 64'd0);
            check($sformatf("stall_wdata_%0d", i), 64'(ram_wdata), 64'(exp_w0));
        end
        check("stall_no_second_write", 64'(wr_addr.size() - n0), 64'd1);
        ram_ry = 1'b1;
        tick;
        check("stall_w1_cs_n", 64'(ram_cs_n), 64'd0);
        check("stall_w1_addr", 64'(ram_addr), 64'd1);
        check("reduce_word1", 64'(ram_wdata), 64'(exp_w1));
        ram_ry = 1'b0;
        tick;

        // Reset mid-WAIT
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick;
        rst = 1'b1;
        ram_ry = 1'b1;
        tick;
        check("postreset_busy", 64'(busy), 64'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        send_vec(1'b0, pat_vec(0));
        check("postreset_addr", 64'(ram_addr), 64'd0);
        check("postreset_wdata", 64'(ram_wdata), 64'h00020001);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;

        // Address wrap on the small instance
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        check("wrap_overflow_start", 64'(overflow2), 64'd0);
        for (int v = 0; v < 3; v++) send_vec(1'b1, pat_vec(v));
        wait_done(1'b1);
        check("wrap_write_count", 64'(wr_addr2.size()), 64'd6);
        for (int i = 0; i < 6 && i < wr_addr2.size(); i++) begin
            check($sformatf("wrap_addr_%0d", i), 64'(wr_addr2[i]), 64'(i % 4));
            check($sformatf("wrap_ovf_%0d", i), 64'(wr_ovf2[i]), 64'(i >= 4));
        end
        check("wrap_overflow_held", 64'(overflow2), 64'd1);
        tick;
        check("wrap_overflow_idle", 64'(overflow2), 64'd1);
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        check("wrap_overflow_cleared", 64'(overflow2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mu_writeback_ctrl.md
Name: mu_writeback_ctrl

Overview:
- Parametrised write-back engine between the multiply/accumulate array and the result SRAM.
- Accepts vectors of N_CH accumulator results over a valid/ready handshake and reduces each result to W_PACK bits.
- Packs each vector into RAM_W-bit words and writes the words sequentially to SRAM through an active-low cs_n/we_n interface, honouring the SRAM ready flag.
- Counts vectors per job and signals row and job completion to the controller.

Parameters:
- N_CH, 4, number of result channels per vector.
- W_MU, 17, width of one unsigned accumulator result.
- W_PACK, 16, stored width per result. Constraint: (N_CH*W_PACK) % RAM_W == 0 and W_PACK <= W_MU.
- RAM_W, 32, SRAM data width.
- ADDR_W, 8, SRAM address width.
- BASE_ADDR, 0, first write address of a job.
- DEPTH, 256, number of usable addresses; the address wraps after BASE_ADDR+DEPTH-1.
- NUM_VEC, 8, number of vectors per job.
- Derived: WPV = N_CH*W_PACK/RAM_W, the number of words per vector (2 at defaults).

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle job start request. Honoured only in IDLE.
- in_valid, in, 1, mu_in holds a valid vector.
- in_ready, out, 1, block can accept a vector this cycle.
- mu_in, in, N_CH*W_MU, channel k occupies bits [k*W_MU +: W_MU].
- ram_ry, in, 1, SRAM ready; high means the previous access is complete.
- ram_cs_n, out, 1, SRAM chip select, active low.
- ram_we_n, out, 1, SRAM write enable, active low.
- ram_addr, out, ADDR_W, SRAM address.
- ram_wdata, out, RAM_W, SRAM write data.
- row_done, out, 1, one-cycle pulse when the last word of a vector is acknowledged.
- ram_done, out, 1, one-cycle pulse when the job is complete.
- busy, out, 1, high in every state except IDLE.
- overflow, out, 1, sticky flag: an address wrap occurred during the current job.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - in_ready=0, ram_cs_n=1, ram_we_n=1, ram_addr=BASE_ADDR, ram_wdata=0.
  - row_done=0, ram_done=0, busy=0, overflow=0.
  - All counters clear.
  - Reset mid-job aborts any write in progress immediately; no partial state survives.
- IDLE:
  - On start=1: load addr=BASE_ADDR, clear vec_cnt and overflow, go to ACCEPT.
- ACCEPT:
  - in_ready=1.
  - On in_valid=1: capture the vector, reduce each channel to W_PACK bits, pack, set word_idx=0, go to WRITE.
  - Packing order: channel 0 goes in the LSBs of word 0; channels fill words in ascending order.
  - Reduction (default): keep the low W_PACK bits of each channel (truncate).
- WRITE (exactly one cycle):
  - ram_cs_n=0, ram_we_n=0, ram_addr=addr, ram_wdata=word[word_idx].
  - Go to WAIT.
- WAIT:
  - ram_cs_n=1, ram_we_n=1.
  - ram_addr and ram_wdata hold their WRITE values.
  - Stay while ram_ry=0.
  - On ram_ry=1, advance the address: addr+1, or BASE_ADDR if addr==BASE_ADDR+DEPTH-1 (this wrap also sets overflow=1).
  - If word_idx<WPV-1: increment word_idx, go to WRITE.
  - Otherwise: pulse row_done and increment vec_cnt. Go to DONE if vec_cnt==NUM_VEC-1, else go to ACCEPT.
- DONE:
  - ram_done=1 for one cycle, then go to IDLE.
- Latency and throughput:
  - The first WRITE cycle is the cycle after the handshake.
  - With ram_ry held at 1, each word takes 2 cycles, so a vector takes 2*WPV cycles plus 1 cycle in ACCEPT.
- Boundary rules:
  - start outside IDLE is ignored.
  - in_valid outside ACCEPT is ignored, and in_ready is 0 there.
  - If ram_ry stays 0, the block waits indefinitely; there is no timeout.
  - overflow holds until the next accepted start or reset.
  - busy=1 in ACCEPT, WRITE, WAIT and DONE.

Optional Feature:
- Macro: MU_WB_SATURATE_EN.
- Defined: each channel is clamped to 2^W_PACK-1 when its value is >= 2^W_PACK; otherwise it passes unchanged.
- Undefined: each channel is truncated to its low W_PACK bits.
- Only the reduction logic differs; all other behaviour and timing are identical.

Test Plan:
- Reset: hold rst=0 mid-WAIT, then release -> all outputs at their reset values, busy=0, and the next start begins at BASE_ADDR.
- Single vector: defaults, start, then mu_in = {ch3=0x00004, ch2=0x00003, ch1=0x00002, ch0=0x00001}, ram_ry=1 -> write 0x00020001 @0, then 0x00040003 @1, row_done after the second acknowledge.
- Full job: NUM_VEC=8, ram_ry=1 -> 16 writes to addresses 0..15, exactly 8 row_done pulses, ram_done one cycle after the last, and in_ready=0 outside ACCEPT.
- SRAM stall: hold ram_ry=0 for 5 cycles after the first write -> ram_cs_n, ram_we_n, ram_addr and ram_wdata stable, with no second write until ram_ry=1.
- Wrap: DEPTH=4, NUM_VEC=3 -> addresses 0, 1, 2, 3, 0, 1; overflow=1 from the acknowledge at address 3 until the next start.
- Reduction: ch0=0x1ABCD -> low half of word 0 is 0xABCD without MU_WB_SATURATE_EN and 0xFFFF with it.
